vw_pe_sequencer: RTL
====================

# vw_pe_sequencer

Element sequencer for the vector PE datapath. It accepts one vector arithmetic command at a time and validates its element width and widening mode. It then steps through elements `0..vl-1`, issuing one operand read per cycle. One cycle later it presents each element to the PE and sign-extension stage, together with its static `vsew`/`widening`/`signed` controls. It rejects width/widening combinations the sign-extension stage cannot perform, so that stage never sees them.

## Interface

Parameters:
- `MAX_VL`, 32: maximum element count per command.
- `IDX_W`, `$clog2(MAX_VL+1)`: width of the count and index fields.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_vl`  in  IDX_W  element count.
- `cmd_vsew`  in  2  source element width: 0=8b, 1=16b, 2=32b.
- `cmd_widening`  in  2  0=none, 1=double, 2=quad.
- `cmd_signed`  in  1  signed operands.
- `rd_valid`  out  1  operand read request for element `rd_idx`.
- `rd_idx`  out  IDX_W  element index being read.
- `pe_valid`  out  1  element presented to the PE.
- `pe_idx`  out  IDX_W  index of the presented element.
- `pe_first`, `pe_last`  out  1 each  first/last element markers.
- `pe_vsew`, `pe_widening`  out  2 each  latched command controls.
- `pe_signed`  out  1  latched `cmd_signed`.
- `pe_dst_sew`  out  2  destination width, `vsew + widening`.
- `pe_stall`  in  1  PE cannot accept the presented element.
- `done`  out  1  one-cycle pulse: command completed.
- `err`  out  1  one-cycle pulse: command rejected.

## Operation

- States: IDLE, RUN, DRAIN, ERR.
- `cmd_ready` = (state==IDLE). A command is accepted on `cmd_valid && cmd_ready`, and all `cmd_*` fields are latched.
- Illegal command, checked at acceptance:
  - `vsew==3`;
  - `widening==3`;
  - `widening!=0 && vsew==2`;
  - `widening==2 && vsew==1`;
  - `vl>MAX_VL`.
- An illegal command goes IDLE→ERR. ERR lasts one cycle with `err=1`, then returns to IDLE. No reads or PE valids are issued.
- A legal command with `vl==0` goes IDLE→DRAIN. DRAIN sees an empty stage 1, so `done` pulses in the next cycle.
- A legal command with `vl>0` goes IDLE→RUN with the issue counter `cnt=0`.
- Stage 0 (RUN): `rd_valid=!pe_stall`, `rd_idx=cnt`. On each issue `cnt` increments. Issuing `cnt==vl-1` moves the state to DRAIN.
- Stage 1: a register loaded from stage 0 when `!pe_stall`.
  - It carries `pe_valid`, `pe_idx`, and `pe_first` (idx==0) / `pe_last` (idx==vl-1).
  - If no read was issued in the previous cycle, it loads `pe_valid=0`.
- `pe_stall` high freezes everything:
  - stage 1 holds all of its outputs;
  - no read is issued and `cnt` holds.
  - The operand store must hold its read data while `rd_valid` is low.
- DRAIN: once stage 1 is empty, or the `pe_last` element is accepted (`pe_valid && pe_last && !pe_stall`), the state goes to IDLE. `done` is a registered pulse in the first IDLE cycle.
- `pe_vsew`, `pe_widening`, `pe_signed`, `pe_dst_sew` are static registers, updated only on acceptance.
- A new command is never accepted while RUN, DRAIN or ERR is active. `cmd_ready` rises in the same cycle as `done`/`err`'s following IDLE.
- Reset, asserted at any time including mid-command:
  - the state goes to IDLE and `cnt=0`;
  - all registered outputs go to 0: `rd_valid`, `pe_valid`, `pe_idx`, `pe_first`, `pe_last`, `pe_vsew`, `pe_widening`, `pe_signed`, `pe_dst_sew`, `done`, `err`;
  - `cmd_ready=1`.
  - The in-flight command is dropped with no `done`.

## Timing

- Command accepted at the edge ending cycle 0:
  - cycle 1: `rd_valid`, `rd_idx=0`;
  - cycle 2: `pe_valid`, `pe_idx=0`, `pe_first=1`.
- No stalls, `vl=N`:
  - reads in cycles 1..N;
  - PE valids in cycles 2..N+1;
  - `done` and `cmd_ready` in cycle N+2.
  - Command-to-command spacing is N+2 cycles.
- Each stall cycle extends completion by exactly one cycle. No element is dropped or duplicated.
- `vl=1`: `pe_first` and `pe_last` are both high on the same element.
- `vl=0`: `done` pulses 2 cycles after acceptance.
- Illegal command: `err` pulses in cycle 1 and `cmd_ready` returns in cycle 2.
- Read-to-PE latency is fixed at 1 cycle.

## Test plan

- Legal, no stall: vl=4, vsew=0, widening=1, signed=1.
  - Required: `rd_idx` 0,1,2,3 in cycles 1-4; `pe_idx` 0-3 in cycles 2-5; `pe_dst_sew=1`; `done` in cycle 6 only.
- Stall mid-stream: vl=3, `pe_stall` high in cycles 3-4.
  - Required: `pe_idx=1` held through cycles 3-5; `rd_valid` low in cycles 3-4; `done` in cycle 7; each index seen accepted once.
- Illegal commands, each sent separately: (vsew=1, widening=2), (vsew=2, widening=1), widening=3, vl=MAX_VL+1.
  - Required: `err` one-cycle pulse, zero `rd_valid`/`pe_valid`, `cmd_ready` back 2 cycles after acceptance.
- Boundaries: vl=0 and vl=MAX_VL.
  - vl=0: `done` 2 cycles after acceptance, no valids.
  - vl=MAX_VL: `pe_last` at idx 31, no wrap of `cnt`.
- Reset mid-command: vl=8, reset asserted after `pe_idx=3`.
  - Required: all outputs 0 immediately (asynchronous), `cmd_ready=1`, no `done`.
  - A new vl=2 command after reset runs cleanly.
- Back-to-back: `cmd_valid` held high with two vl=2 commands.
  - Required: the second is accepted in the `done` cycle; `pe_vsew`/`pe_widening` change only at the second acceptance.

Source files
------------

// File: rtl/vw_pe_sequencer_if.sv
// Bundle of the command, operand-read and PE-presentation signals of the
// vector PE element sequencer.
//   slave  : the sequencer itself (takes commands and pe_stall, drives the rest)
//   master : the command source / PE side that talks to the sequencer
interface vw_pe_sequencer_if #(
  parameter int IDX_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_vl;
  logic [1:0]       cmd_vsew;
  logic [1:0]       cmd_widening;
  logic             cmd_signed;

  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;

  logic             pe_valid;
  logic [IDX_W-1:0] pe_idx;
  logic             pe_first;
  logic             pe_last;
  logic [1:0]       pe_vsew;
  logic [1:0]       pe_widening;
  logic             pe_signed;
  logic [1:0]       pe_dst_sew;
  logic             pe_stall;

  logic             done;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_vl, cmd_vsew, cmd_widening, cmd_signed, pe_stall,
    output cmd_ready, rd_valid, rd_idx, pe_valid, pe_idx, pe_first, pe_last,
           pe_vsew, pe_widening, pe_signed, pe_dst_sew, done, err
  );

  modport master (
    output cmd_valid, cmd_vl, cmd_vsew, cmd_widening, cmd_signed, pe_stall,
    input  cmd_ready, rd_valid, rd_idx, pe_valid, pe_idx, pe_first, pe_last,
           pe_vsew, pe_widening, pe_signed, pe_dst_sew, done, err
  );
endinterface

// File: rtl/vw_pe_sequencer.sv
// Element sequencer for the vector PE datapath.
// Accepts one command at a time, rejects width/widening combinations the
// sign-extension stage cannot perform, then issues one operand read per cycle
// for elements 0..vl-1 and presents each element to the PE one cycle later.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : vw_pe_sequencer_if.slave
//            cmd_*    command handshake and fields (vl, vsew, widening, signed)
//            rd_*     operand read request (stage 0)
//            pe_*     element presentation and static controls (stage 1),
//                     pe_stall freezes both stages
//            done/err one-cycle completion / rejection pulses
module vw_pe_sequencer #(
  parameter int MAX_VL = 32,
  parameter int IDX_W  = $clog2(MAX_VL + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  vw_pe_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state, state_nx;

  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] vl_q;
  logic [IDX_W-1:0] vl_last;

  logic             accept;
  logic             illegal;
  logic             issue;
  logic             cmd_ready_c;
  logic             err_c;
  logic             done_set;

  logic             pe_valid_q;
  logic [IDX_W-1:0] pe_idx_q;
  logic             pe_first_q;
  logic             pe_last_q;
  logic [1:0]       vsew_q;
  logic [1:0]       wid_q;
  logic             sgn_q;
  logic [1:0]       dst_q;
  logic             done_q;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign vl_last = vl_q - IDX_W'(1);

  // Combinations the sign-extension stage cannot produce (destination wider
  // than 32b, reserved encodings) plus oversize element counts.
  always_comb begin
    illegal = 1'b0;
    if (bus.cmd_vsew == 2'd3)                                illegal = 1'b1;
    if (bus.cmd_widening == 2'd3)                            illegal = 1'b1;
    if (bus.cmd_widening != 2'd0 && bus.cmd_vsew == 2'd2)    illegal = 1'b1;
    if (bus.cmd_widening == 2'd2 && bus.cmd_vsew == 2'd1)    illegal = 1'b1;
    if (bus.cmd_vl > IDX_W'(MAX_VL))                         illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cmd_ready_c = 1'b0;
    issue       = 1'b0;
    err_c       = 1'b0;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (accept) begin
          if (illegal)                    state_nx = ERR;
          else if (bus.cmd_vl == '0)      state_nx = DRAIN;
          else                            state_nx = RUN;
        end
      end
      RUN: begin
        issue = !bus.pe_stall;
        if (issue && cnt == vl_last) state_nx = DRAIN;
      end
      DRAIN: begin
        // Stage 1 is either empty (vl==0) or holds the last element.
        if (!pe_valid_q || (pe_last_q && !bus.pe_stall)) begin
          state_nx = IDLE;
          done_set = 1'b1;
        end
      end
      ERR: begin
        err_c    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issue counter and command latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      vl_q   <= '0;
      vsew_q <= '0;
      wid_q  <= '0;
      sgn_q  <= 1'b0;
      dst_q  <= '0;
    end else begin
      if (accept)      cnt <= '0;
      else if (issue)  cnt <= cnt + IDX_W'(1);
      // Only legal commands reach the PE controls, so the sign-extension
      // stage never sees an unsupported width/widening pair.
      if (accept && !illegal) begin
        vl_q   <= bus.cmd_vl;
        vsew_q <= bus.cmd_vsew;
        wid_q  <= bus.cmd_widening;
        sgn_q  <= bus.cmd_signed;
        dst_q  <= bus.cmd_vsew + bus.cmd_widening;
      end
    end
  end

  // Stage 1: element presentation register, frozen while the PE stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_valid_q <= 1'b0;
      pe_idx_q   <= '0;
      pe_first_q <= 1'b0;
      pe_last_q  <= 1'b0;
    end else if (!bus.pe_stall) begin
      pe_valid_q <= issue;
      if (issue) begin
        pe_idx_q   <= cnt;
        pe_first_q <= (cnt == '0);
        pe_last_q  <= (cnt == vl_last);
      end else begin
        pe_first_q <= 1'b0;
        pe_last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_set;
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.rd_valid    = issue;
  assign bus.rd_idx      = cnt;
  assign bus.pe_valid    = pe_valid_q;
  assign bus.pe_idx      = pe_idx_q;
  assign bus.pe_first    = pe_first_q;
  assign bus.pe_last     = pe_last_q;
  assign bus.pe_vsew     = vsew_q;
  assign bus.pe_widening = wid_q;
  assign bus.pe_signed   = sgn_q;
  assign bus.pe_dst_sew  = dst_q;
  assign bus.done        = done_q;
  assign bus.err         = err_c;

endmodule
